// File: rtl/pll_phase_step_ctrl.sv
// Phase-step sequencer for the emulated PLL: one request at a time, one phasestep/phasedone handshake per step.
// Optional phasedone watchdog enabled by defining PLL_PHASE_STEP_TIMEOUT_EN.
module pll_phase_step_ctrl #(
  parameter int CNT_SEL_W      = 3,
  parameter int STEP_W         = 8,
  parameter int SETUP_CYCLES   = 1,
  parameter int HOLD_CYCLES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [CNT_SEL_W-1:0] req_cntsel,
  input  logic                 req_updown,
  input  logic [STEP_W-1:0]    req_steps,
  input  logic                 pll_locked,
  input  logic                 phasedone,
  output logic                 phasestep,
  output logic                 phaseupdown,
  output logic [CNT_SEL_W-1:0] phasecounterselect,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [STEP_W-1:0]    steps_left,
  output logic [2:0]           state_dbg
);

  // Request handshake: a request transfers on a rising clk edge where req_valid and
  // req_ready are both high; req_valid seen while req_ready is low is simply not taken.

  if (SETUP_CYCLES < 1 || HOLD_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("pll_phase_step_ctrl: SETUP_CYCLES, HOLD_CYCLES and TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SETUP     = 3'd1,
    S_STEP      = 3'd2,
    S_WAIT_LOW  = 3'd3,
    S_WAIT_HIGH = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t               state, state_n;
  logic [15:0]          cnt, cnt_n;
  logic                 low_seen, low_seen_n;
  logic [CNT_SEL_W-1:0] cntsel_q, cntsel_n;
  logic                 updown_q, updown_n;
  logic [STEP_W-1:0]    steps_q, steps_n;
  logic                 err_q, err_n;
  logic                 accept;
  logic                 waiting;

  assign busy      = (state == S_SETUP) || (state == S_STEP) ||
                     (state == S_WAIT_LOW) || (state == S_WAIT_HIGH);
  assign waiting   = (state == S_WAIT_LOW) || (state == S_WAIT_HIGH);
  assign req_ready = (state == S_IDLE) && pll_locked && phasedone;
  assign accept    = req_valid && req_ready;

  // Strobe is gated by lock so a lock loss kills it in the same cycle.
  assign phasestep          = (state == S_STEP) && pll_locked;
  assign done               = (state == S_DONE);
  assign err                = err_q;
  assign steps_left         = steps_q;
  assign phaseupdown        = updown_q;
  assign phasecounterselect = cntsel_q;
  assign state_dbg          = state;

`ifdef PLL_PHASE_STEP_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;
  logic            to_hit;

  assign to_hit = waiting && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      to_cnt <= '0;
    end else if (state_n != state) begin
      to_cnt <= '0;
    end else if (waiting) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end
`else
  logic to_hit;
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    low_seen_n = low_seen;
    cntsel_n   = cntsel_q;
    updown_n   = updown_q;
    steps_n    = steps_q;
    err_n      = err_q;
    case (state)
      S_IDLE: begin
        if (accept) begin
          cntsel_n   = req_cntsel;
          updown_n   = req_updown;
          steps_n    = req_steps;
          err_n      = 1'b0;
          cnt_n      = '0;
          low_seen_n = 1'b0;
          state_n    = (req_steps == '0) ? S_DONE : S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt == 16'(SETUP_CYCLES - 1)) begin
          cnt_n      = '0;
          low_seen_n = 1'b0;
          state_n    = S_STEP;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      S_STEP: begin
        // A phasedone low already seen while strobing counts as the falling half.
        low_seen_n = low_seen || !phasedone;
        if (cnt == 16'(HOLD_CYCLES - 1)) begin
          cnt_n   = '0;
          state_n = (low_seen || !phasedone) ? S_WAIT_HIGH : S_WAIT_LOW;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      S_WAIT_LOW: begin
        if (!phasedone) state_n = S_WAIT_HIGH;
      end
      S_WAIT_HIGH: begin
        if (phasedone) begin
          if (steps_q != '0) steps_n = steps_q - STEP_W'(1);
          state_n = (steps_q <= STEP_W'(1)) ? S_DONE : S_SETUP;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    if (to_hit && (state_n == state)) begin
      err_n   = 1'b1;
      state_n = S_DONE;
    end

    // Lock loss aborts the request but keeps the count of steps still owed.
    if (busy && !pll_locked) begin
      err_n   = 1'b1;
      steps_n = steps_q;
      state_n = S_DONE;
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      low_seen <= 1'b0;
      cntsel_q <= '0;
      updown_q <= 1'b0;
      steps_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      low_seen <= low_seen_n;
      cntsel_q <= cntsel_n;
      updown_q <= updown_n;
      steps_q  <= steps_n;
      err_q    <= err_n;
    end
  end

endmodule

// File: tb/tb_pll_phase_step_ctrl.sv
// Directed bench for pll_phase_step_ctrl with a small PLL phasedone responder.
module tb_pll_phase_step_ctrl;

  localparam int CNT_SEL_W = 3;
  localparam int STEP_W    = 8;
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SETUP     = 3'd1;
  localparam logic [2:0] S_STEP      = 3'd2;
  localparam logic [2:0] S_WAIT_LOW  = 3'd3;
  localparam logic [2:0] S_WAIT_HIGH = 3'd4;

  logic                 clk = 1'b0;
  logic                 areset;
  logic                 req_valid;
  logic                 req_ready;
  logic [CNT_SEL_W-1:0] req_cntsel;
  logic                 req_updown;
  logic [STEP_W-1:0]    req_steps;
  logic                 pll_locked;
  logic                 phasedone = 1'b1;
  logic                 phasestep;
  logic                 phaseupdown;
  logic [CNT_SEL_W-1:0] phasecounterselect;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic [STEP_W-1:0]    steps_left;
  logic [2:0]           state_dbg;

  int checks = 0;
  int errors = 0;

  logic              model_en = 1'b1;
  logic              ps_prev  = 1'b0;
  logic [2:0]        pd_cnt   = 3'd0;

  logic [STEP_W-1:0] exp_q[$];
  logic [STEP_W-1:0] obs_q[$];
  int                pulses, dones, min_gap, gap, timed_out, busy_seen;

  pll_phase_step_ctrl #(
    .CNT_SEL_W(CNT_SEL_W), .STEP_W(STEP_W), .SETUP_CYCLES(1), .HOLD_CYCLES(2), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .areset(areset), .req_valid(req_valid), .req_ready(req_ready),
    .req_cntsel(req_cntsel), .req_updown(req_updown), .req_steps(req_steps),
    .pll_locked(pll_locked), .phasedone(phasedone), .phasestep(phasestep),
    .phaseupdown(phaseupdown), .phasecounterselect(phasecounterselect),
    .busy(busy), .done(done), .err(err), .steps_left(steps_left), .state_dbg(state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // PLL responder: phasedone drops 1 cycle after the strobe rises, returns 3 cycles later.
  always @(posedge clk) begin
    ps_prev <= phasestep;
    if (!model_en) begin
      phasedone <= 1'b1;
      pd_cnt    <= 3'd0;
    end else if (phasestep && !ps_prev) begin
      phasedone <= 1'b0;
      pd_cnt    <= 3'd3;
    end else if (pd_cnt != 3'd0) begin
      pd_cnt <= pd_cnt - 3'd1;
      if (pd_cnt == 3'd1) phasedone <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: leaves the caller at the negedge right after the accepting edge.
  task automatic send(input logic [CNT_SEL_W-1:0] sel, input logic ud, input logic [STEP_W-1:0] st);
    @(negedge clk);
    req_valid  = 1'b1;
    req_cntsel = sel;
    req_updown = ud;
    req_steps  = st;
    chk("req_ready_at_send", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, input string tag);
    int n = 0;
    while (state_dbg !== st && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, (state_dbg === st), 1);
  endtask

  task automatic observe(input int budget);
    logic [STEP_W-1:0] last_sl;
    logic              ps_last;
    pulses = 0; dones = 0; min_gap = 1000; gap = 0; timed_out = 1; busy_seen = 0;
    ps_last = 1'b0;
    last_sl = '0;
    for (int i = 0; i < budget; i++) begin
      if (phasestep && !ps_last) begin
        pulses++;
        if (pulses > 1 && gap < min_gap) min_gap = gap;
      end
      if (!phasestep) gap++; else gap = 0;
      ps_last = phasestep;
      if (busy) busy_seen = 1;
      if (i == 0 || steps_left !== last_sl) obs_q.push_back(steps_left);
      last_sl = steps_left;
      if (done) begin
        dones++;
        timed_out = 0;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    areset     = 1'b1;
    req_valid  = 1'b0;
    req_cntsel = '0;
    req_updown = 1'b0;
    req_steps  = '0;
    pll_locked = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_phasestep", phasestep, 0);
    chk("rst_steps_left", steps_left, 0);
    chk("rst_cntsel", phasecounterselect, 0);
    chk("rst_updown", phaseupdown, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_state", state_dbg, S_IDLE);
    @(negedge clk);
    areset = 1'b0;

    // Single step
    send(3'd2, 1'b1, 8'd1);
    chk("s1_cntsel", phasecounterselect, 2);
    chk("s1_updown", phaseupdown, 1);
    chk("s1_setup_ps", phasestep, 0);
    chk("s1_busy", busy, 1);
    chk("s1_steps_left", steps_left, 1);
    @(negedge clk); chk("s1_ps_hi0", phasestep, 1);
    @(negedge clk); chk("s1_ps_hi1", phasestep, 1);
    @(negedge clk); chk("s1_ps_lo", phasestep, 0);
    chk("s1_busy_wait", busy, 1);
    repeat (3) @(negedge clk);
    chk("s1_done", done, 1);
    chk("s1_steps_zero", steps_left, 0);
    chk("s1_err", err, 0);
    chk("s1_busy_done", busy, 0);
    @(negedge clk);
    chk("s1_done_once", done, 0);
    chk("s1_ready_again", req_ready, 1);

    // Multi step
    exp_q = {8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
    obs_q.delete();
    send(3'd1, 1'b0, 8'd5);
    chk("m5_updown", phaseupdown, 0);
    observe(200);
    chk("m5_no_timeout", timed_out, 0);
    chk("m5_pulses", pulses, 5);
    chk("m5_gap_ge2", (min_gap >= 2), 1);
    chk("m5_sl_count", obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0)
      chk("m5_steps_left_seq", obs_q.pop_front(), exp_q.pop_front());
    @(negedge clk);
    chk("m5_done_once", done, 0);

    // Zero steps
    send(3'd3, 1'b1, 8'd0);
    chk("z_done", done, 1);
    chk("z_busy", busy, 0);
    chk("z_ps", phasestep, 0);
    chk("z_cntsel", phasecounterselect, 3);
    @(negedge clk);
    chk("z_done_once", done, 0);
    chk("z_busy_after", busy, 0);

    // Lock loss during the second WAIT_HIGH
    send(3'd4, 1'b1, 8'd4);
    wait_state(S_WAIT_HIGH, 20, "ll_wh1");
    wait_state(S_SETUP, 20, "ll_setup2");
    wait_state(S_WAIT_HIGH, 20, "ll_wh2");
    pll_locked = 1'b0;
    #1;
    chk("ll_ps_low", phasestep, 0);
    chk("ll_ready_low", req_ready, 0);
    @(negedge clk);
    chk("ll_done", done, 1);
    chk("ll_err", err, 1);
    chk("ll_steps_left", steps_left, 3);
    chk("ll_busy", busy, 0);
    repeat (4) @(negedge clk);
    chk("ll_ready_unlocked", req_ready, 0);
    chk("ll_err_sticky", err, 1);
    pll_locked = 1'b1;
    @(negedge clk);
    chk("ll_ready_relock", req_ready, 1);
    send(3'd0, 1'b0, 8'd0);
    chk("ll_err_cleared", err, 0);
    chk("ll_next_done", done, 1);

    // Reset mid-operation
    send(3'd5, 1'b1, 8'd3);
    wait_state(S_STEP, 10, "rm_step");
    chk("rm_ps_before", phasestep, 1);
    areset = 1'b1;
    #1;
    chk("rm_ps", phasestep, 0);
    chk("rm_busy", busy, 0);
    chk("rm_done", done, 0);
    chk("rm_state", state_dbg, S_IDLE);
    chk("rm_steps_left", steps_left, 0);
    @(negedge clk);
    areset = 1'b0;
    observe(12);
    chk("rm_no_done", dones, 0);
    chk("rm_no_busy", busy_seen, 0);

    // Phasedone never falls
    model_en = 1'b0;
    repeat (2) @(negedge clk);
    send(3'd1, 1'b1, 8'd1);
`ifdef PLL_PHASE_STEP_TIMEOUT_EN
    begin
      int n = 0;
      while (!done && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("to_latency", n, 19);
      chk("to_err", err, 1);
      chk("to_done", done, 1);
    end
`else
    observe(40);
    chk("nto_no_done", dones, 0);
    chk("nto_busy", busy, 1);
    chk("nto_state", state_dbg, S_WAIT_LOW);
    areset = 1'b1;
    @(negedge clk);
    areset = 1'b0;
`endif
    model_en = 1'b1;
    @(negedge clk);
    chk("end_idle", state_dbg, S_IDLE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
